// File: rtl/knn_vote_pkg.sv
// rtl/knn_vote_pkg.sv - shared knn defaults, vote FSM encoding and vote weight helper
package knn_vote_pkg;

  // Defaults shared with knn_core
  localparam int KNN_DATA_W      = 32;
  localparam int KNN_LABEL_W     = 8;
  localparam int KNN_N_NEIGHBOUR = 4;
  localparam int KNN_N_CLASSES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } vote_state_e;

  // Rank weight: nearest slot gets n_neighbour, farthest gets 1; flat 1 otherwise
  function automatic int vote_weight(input int slot, input int n_neighbour, input bit weighted);
    return weighted ? (n_neighbour - slot) : 1;
  endfunction

endpackage

// File: rtl/knn_vote_hist.sv
// rtl/knn_vote_hist.sv - per-class vote counters and first-occurrence slot table
module knn_vote_hist #(
  parameter int N_CLASSES  = 16,
  parameter int CNT_W      = 4,
  parameter int CLS_IDX_W  = 4,
  parameter int SLOT_IDX_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc_en,
  input  logic [CLS_IDX_W-1:0]  inc_idx,
  input  logic [CNT_W-1:0]      inc_w,
  input  logic [SLOT_IDX_W-1:0] inc_slot,
  input  logic [CLS_IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]      rd_cnt,
  output logic [SLOT_IDX_W-1:0] rd_first
);

  logic [CNT_W-1:0]      cnt   [N_CLASSES];
  logic [SLOT_IDX_W-1:0] first [N_CLASSES];

  // Clear on reset/accept; add weight and record the slot of a class's first vote
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int c = 0; c < N_CLASSES; c++) begin
        cnt[c]   <= '0;
        first[c] <= '0;
      end
    end else if (inc_en) begin
      cnt[inc_idx] <= cnt[inc_idx] + inc_w;
      if (cnt[inc_idx] == '0) begin
        first[inc_idx] <= inc_slot;
      end
    end
  end

  assign rd_cnt   = cnt[rd_idx];
  assign rd_first = first[rd_idx];

endmodule

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority-vote classifier over knn_core neighbour list; KNN_VOTE_WEIGHTED_EN selects rank-weighted votes
module knn_vote
  import knn_vote_pkg::*;
#(
  parameter int DATA_W      = KNN_DATA_W,
  parameter int LABEL_W     = KNN_LABEL_W,
  parameter int N_NEIGHBOUR = KNN_N_NEIGHBOUR,
  parameter int N_CLASSES   = KNN_N_CLASSES,
  parameter int CNT_W       = $clog2(N_NEIGHBOUR * (N_NEIGHBOUR + 1) / 2 + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [(DATA_W+LABEL_W)*N_NEIGHBOUR-1:0] neighbour_info,
  output logic                                   busy,
  output logic                                   done,
  output logic [LABEL_W-1:0]                     class_out,
  output logic [CNT_W-1:0]                       votes_out,
  output logic                                   no_vote
);

  localparam int SLOT_W     = DATA_W + LABEL_W;
  localparam int SLOT_IDX_W = (N_NEIGHBOUR > 1) ? $clog2(N_NEIGHBOUR) : 1;
  localparam int CLS_IDX_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [LABEL_W:0] NCLS_LBL = (LABEL_W + 1)'(N_CLASSES);
`ifdef KNN_VOTE_WEIGHTED_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  vote_state_e state, state_nxt;

  logic [SLOT_W*N_NEIGHBOUR-1:0] info_q;
  logic [SLOT_IDX_W-1:0]         slot_cnt;
  logic [CLS_IDX_W-1:0]          cls_cnt;
  logic                          any_valid;
  logic [CNT_W-1:0]              best_cnt;
  logic [CLS_IDX_W-1:0]          best_cls;
  logic [SLOT_IDX_W-1:0]         best_first;

  logic                  accept, count_en, scan_en, out_en;
  logic [LABEL_W-1:0]    cur_label;
  logic [DATA_W-1:0]     cur_dist;
  logic                  slot_valid, label_ok;
  logic [CNT_W-1:0]      cur_w, rd_cnt;
  logic [SLOT_IDX_W-1:0] rd_first;
  logic                  replace;

  // The latch shifts down one slot per COUNT cycle, so slot 0 is always current
  assign cur_label  = info_q[LABEL_W-1:0];
  assign cur_dist   = info_q[SLOT_W-1:LABEL_W];
  assign slot_valid = (cur_dist != '1);
  assign label_ok   = ({1'b0, cur_label} < NCLS_LBL);
  assign cur_w      = CNT_W'(vote_weight(int'(slot_cnt), N_NEIGHBOUR, WEIGHTED));

  knn_vote_hist #(
    .N_CLASSES  (N_CLASSES),
    .CNT_W      (CNT_W),
    .CLS_IDX_W  (CLS_IDX_W),
    .SLOT_IDX_W (SLOT_IDX_W)
  ) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .inc_en   (count_en && slot_valid && label_ok),
    .inc_idx  (cur_label[CLS_IDX_W-1:0]),
    .inc_w    (cur_w),
    .inc_slot (slot_cnt),
    .rd_idx   (cls_cnt),
    .rd_cnt   (rd_cnt),
    .rd_first (rd_first)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state: fixed-length COUNT and SCAN phases
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_COUNT;
      ST_COUNT: if (slot_cnt == SLOT_IDX_W'(N_NEIGHBOUR - 1)) state_nxt = ST_SCAN;
      ST_SCAN:  if (cls_cnt == CLS_IDX_W'(N_CLASSES - 1)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: phase enables and busy
  always_comb begin
    accept   = (state == ST_IDLE) && start;
    count_en = (state == ST_COUNT);
    scan_en  = (state == ST_SCAN);
    out_en   = (state == ST_DONE);
    busy     = (state != ST_IDLE);
  end

  // Latch the list on accept and walk it slot by slot during COUNT
  always_ff @(posedge clk) begin
    if (rst) begin
      info_q    <= '0;
      slot_cnt  <= '0;
      any_valid <= 1'b0;
    end else if (accept) begin
      info_q    <= neighbour_info;
      slot_cnt  <= '0;
      any_valid <= 1'b0;
    end else if (count_en) begin
      info_q   <= info_q >> SLOT_W;
      slot_cnt <= slot_cnt + SLOT_IDX_W'(1);
      if (slot_valid) any_valid <= 1'b1;
    end
  end

  // Ties keep the class whose first vote came from the nearer slot
  assign replace = (rd_cnt > best_cnt) ||
                   ((rd_cnt == best_cnt) && (best_cnt != '0) && (rd_first < best_first));

  // Best-class tracker stepping through the histogram during SCAN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cls_cnt    <= '0;
      best_cnt   <= '0;
      best_cls   <= '0;
      best_first <= '0;
    end else if (scan_en) begin
      cls_cnt <= cls_cnt + CLS_IDX_W'(1);
      if (replace) begin
        best_cnt   <= rd_cnt;
        best_cls   <= cls_cnt;
        best_first <= rd_first;
      end
    end
  end

  // Result registers and one-cycle done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      class_out <= '0;
      votes_out <= '0;
      no_vote   <= 1'b0;
    end else begin
      done <= out_en;
      if (out_en) begin
        class_out <= LABEL_W'(best_cls);
        votes_out <= best_cnt;
        no_vote   <= ~any_valid;
      end
    end
  end

endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - randomized and directed bench for knn_vote against a histogram reference model
module tb_knn_vote;

  localparam int DATA_W  = 32;
  localparam int LABEL_W = 8;
  localparam int N       = 4;
  localparam int NC      = 16;
  localparam int CNT_W   = $clog2(N * (N + 1) / 2 + 1);
  localparam int SLOT_W  = DATA_W + LABEL_W;
  localparam int INFO_W  = SLOT_W * N;
  localparam int LAT     = N + NC + 1;
`ifdef KNN_VOTE_WEIGHTED_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [INFO_W-1:0] neighbour_info;
  logic              busy, done, no_vote;
  logic [LABEL_W-1:0] class_out;
  logic [CNT_W-1:0]  votes_out;

  int n_checks = 0;
  int n_fail   = 0;

  knn_vote dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .neighbour_info (neighbour_info),
    .busy           (busy),
    .done           (done),
    .class_out      (class_out),
    .votes_out      (votes_out),
    .no_vote        (no_vote)
  );

  always #5 clk = ~clk;

  function automatic logic [INFO_W-1:0] build_info(input int lab[N], input int emp[N]);
    logic [INFO_W-1:0]  v;
    logic [DATA_W-1:0]  d;
    logic [LABEL_W-1:0] lb;
    v = '0;
    for (int i = 0; i < N; i++) begin
      d = $urandom;
      if (d == '1) d = '0;
      if (emp[i] != 0) d = '1;
      lb = lab[i][LABEL_W-1:0];
      v[i*SLOT_W +: SLOT_W] = {d, lb};
    end
    return v;
  endfunction

  function automatic logic [INFO_W-1:0] junk_info();
    logic [INFO_W-1:0] v;
    for (int j = 0; j < INFO_W / 32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Tally votes per class, then the winner is the class of the nearest slot holding a maximal tally
  task automatic ref_model(input int lab[N], input int emp[N],
                           output int e_cls, output int e_votes, output int e_nv);
    int votes [NC];
    int max_v;
    for (int c = 0; c < NC; c++) votes[c] = 0;
    e_nv = 1;
    for (int i = 0; i < N; i++) begin
      if (emp[i] == 0) begin
        e_nv = 0;
        if (lab[i] < NC) votes[lab[i]] += WEIGHTED ? (N - i) : 1;
      end
    end
    max_v = 0;
    for (int c = 0; c < NC; c++) if (votes[c] > max_v) max_v = votes[c];
    e_cls = 0;
    e_votes = max_v;
    if (max_v > 0) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (emp[i] == 0 && lab[i] < NC && votes[lab[i]] == max_v) e_cls = lab[i];
      end
    end
  endtask

  // Starts one vote, scrambles the input after accept, returns edges-to-done (0 on timeout)
  task automatic run_vote(input logic [INFO_W-1:0] info, output int lat,
                          output int r_cls, output int r_votes, output int r_nv);
    @(negedge clk);
    neighbour_info = info;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    neighbour_info = junk_info();
    lat = 0;
    r_cls = -1; r_votes = -1; r_nv = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        r_cls = int'(class_out);
        r_votes = int'(votes_out);
        r_nv = int'(no_vote);
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    neighbour_info = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (class_out !== '0) begin n_fail++; $display("FAIL reset_class got %0d want 0", class_out); end
    n_checks++; if (votes_out !== '0) begin n_fail++; $display("FAIL reset_votes got %0d want 0", votes_out); end
    n_checks++; if (no_vote !== 1'b0) begin n_fail++; $display("FAIL reset_no_vote got %b want 0", no_vote); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int d_lab [6][N];
    int d_emp [6][N];
    int d_cls [6];
    int d_vu [6];
    int d_vw [6];
    int d_nv [6];
    int lab [N];
    int emp [N];
    int lat, rc, rv, rn, ev;
    d_lab = '{'{3, 3, 5, 7}, '{5, 2, 2, 5}, '{1, 2, 3, 2}, '{4, 6, 0, 0}, '{0, 0, 0, 0}, '{20, 20, 9, 20}};
    d_emp = '{'{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 1, 1}, '{1, 1, 1, 1}, '{0, 0, 0, 0}};
    d_cls = '{3, 5, WEIGHTED ? 1 : 2, 4, 0, 9};
    d_vu  = '{2, 2, 2, 1, 0, 1};
    d_vw  = '{7, 5, 4, 4, 0, 2};
    d_nv  = '{0, 0, 0, 0, 1, 0};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) begin lab[i] = d_lab[t][i]; emp[i] = d_emp[t][i]; end
      ev = WEIGHTED ? d_vw[t] : d_vu[t];
      run_vote(build_info(lab, emp), lat, rc, rv, rn);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL dir%0d_latency got %0d want %0d", t, lat, LAT); end
      n_checks++; if (rc != d_cls[t]) begin n_fail++; $display("FAIL dir%0d_class got %0d want %0d", t, rc, d_cls[t]); end
      n_checks++; if (rv != ev) begin n_fail++; $display("FAIL dir%0d_votes got %0d want %0d", t, rv, ev); end
      n_checks++; if (rn != d_nv[t]) begin n_fail++; $display("FAIL dir%0d_no_vote got %0d want %0d", t, rn, d_nv[t]); end
    end
  endtask

  task automatic test_random();
    int lab [N];
    int emp [N];
    int lat, rc, rv, rn, ec, ev, en;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        lab[i] = $urandom_range(0, (t % 2 == 0) ? 5 : 19);
        emp[i] = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      ref_model(lab, emp, ec, ev, en);
      run_vote(build_info(lab, emp), lat, rc, rv, rn);
      n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", t, lat, LAT); end
      n_checks++; if (rc != ec) begin n_fail++; $display("FAIL rnd%0d_class got %0d want %0d", t, rc, ec); end
      n_checks++; if (rv != ev) begin n_fail++; $display("FAIL rnd%0d_votes got %0d want %0d", t, rv, ev); end
      n_checks++; if (rn != en) begin n_fail++; $display("FAIL rnd%0d_no_vote got %0d want %0d", t, rn, en); end
    end
  endtask

  // start held high: second accept happens in the IDLE cycle where the first done pulses
  task automatic test_back_to_back();
    int lab1 [N];
    int lab2 [N];
    int emp [N];
    int c1, v1, n1, c2, v2, n2;
    int first_k, second_k, rc1, rv1, rc2, rv2;
    logic [INFO_W-1:0] info2;
    for (int i = 0; i < N; i++) begin
      lab1[i] = $urandom_range(0, 5);
      lab2[i] = $urandom_range(6, 12);
      emp[i] = 0;
    end
    ref_model(lab1, emp, c1, v1, n1);
    ref_model(lab2, emp, c2, v2, n2);
    info2 = build_info(lab2, emp);
    @(negedge clk);
    neighbour_info = build_info(lab1, emp);
    start = 1'b1;
    @(posedge clk);
    first_k = 0; second_k = 0; rc1 = -1; rv1 = -1; rc2 = -1; rv2 = -1;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) neighbour_info = info2;
      if (first_k != 0 && k == first_k + 1) start = 1'b0;
      if (done === 1'b1) begin
        if (first_k == 0) begin first_k = k; rc1 = int'(class_out); rv1 = int'(votes_out); end
        else if (second_k == 0) begin second_k = k; rc2 = int'(class_out); rv2 = int'(votes_out); end
      end
    end
    start = 1'b0;
    n_checks++; if (first_k != LAT) begin n_fail++; $display("FAIL b2b_first_done got %0d want %0d", first_k, LAT); end
    n_checks++; if (second_k != 2 * LAT + 1) begin n_fail++; $display("FAIL b2b_second_done got %0d want %0d", second_k, 2 * LAT + 1); end
    n_checks++; if (rc1 != c1 || rv1 != v1) begin n_fail++; $display("FAIL b2b_first_result got %0d/%0d want %0d/%0d", rc1, rv1, c1, v1); end
    n_checks++; if (rc2 != c2 || rv2 != v2) begin n_fail++; $display("FAIL b2b_second_result got %0d/%0d want %0d/%0d", rc2, rv2, c2, v2); end
  endtask

  task automatic test_busy_start();
    int lab [N];
    int emp [N];
    int n_done, done_k, busy_ok;
    lab = '{8, 8, 1, 2};
    emp = '{0, 0, 0, 0};
    @(negedge clk);
    neighbour_info = build_info(lab, emp);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n_done = 0; done_k = 0; busy_ok = 1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) begin n_done++; done_k = k; end
      if (k < LAT && busy !== 1'b1) busy_ok = 0;
      if (k >= LAT && busy !== 1'b0) busy_ok = 0;
      start = (k == 3 || k == LAT - 1) ? 1'b1 : 1'b0;
    end
    n_checks++; if (n_done != 1) begin n_fail++; $display("FAIL busy_start_done_count got %0d want 1", n_done); end
    n_checks++; if (done_k != LAT) begin n_fail++; $display("FAIL busy_start_done_edge got %0d want %0d", done_k, LAT); end
    n_checks++; if (busy_ok != 1) begin n_fail++; $display("FAIL busy_start_busy_window got %0d want 1", busy_ok); end
    n_checks++; if (class_out !== 8'd8) begin n_fail++; $display("FAIL busy_start_class got %0d want 8", class_out); end
  endtask

  task automatic test_reset_mid();
    int lab [N];
    int emp [N];
    int lat, rc, rv, rn, n_done;
    lab = '{7, 7, 7, 7};
    emp = '{0, 0, 0, 0};
    run_vote(build_info(lab, emp), lat, rc, rv, rn);
    n_checks++; if (rc != 7) begin n_fail++; $display("FAIL rstmid_pre_class got %0d want 7", rc); end
    @(negedge clk);
    neighbour_info = build_info(lab, emp);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_checks++; if (class_out !== '0) begin n_fail++; $display("FAIL rstmid_class got %0d want 0", class_out); end
    n_checks++; if (votes_out !== '0) begin n_fail++; $display("FAIL rstmid_votes got %0d want 0", votes_out); end
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", n_done); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
